// File: rtl/circuit_sweep_sequencer_pkg.sv
// Shared types and default constants for the circuit sweep sequencer.
package circuit_sweep_sequencer_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETTLE,
    ST_SAMPLE,
    ST_EMIT,
    ST_FINISH
  } state_t;

  localparam int DEF_NUM_CIRCUITS = 29;
  localparam int SEL_W            = 5;
  localparam int DEF_PAT_W        = 5;
  localparam int DEF_SETTLE_CYC   = 8;

endpackage

// File: rtl/circuit_sweep_sequencer_settle_timer.sv
// Settle interval timer: held at zero while load is high, counts while en is
// high, and flags expire on the last settle cycle.
module circuit_sweep_sequencer_settle_timer #(
  parameter int SETTLE_CYC = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load,
  input  logic en,
  output logic expire
);

  localparam int CW = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;

  logic [CW-1:0] cnt_reg;
  logic [CW-1:0] cnt_next;

  assign expire = (cnt_reg == CW'(SETTLE_CYC - 1));

  // Next count: clear on load, advance while enabled, park once expired.
  always_comb begin
    cnt_next = cnt_reg;
    if (load) begin
      cnt_next = '0;
    end else if (en && !expire) begin
      cnt_next = cnt_reg + CW'(1);
    end
  end

  // Counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_reg <= '0;
    end else begin
      cnt_reg <= cnt_next;
    end
  end

endmodule

// File: rtl/circuit_sweep_sequencer.sv
// Sweeps every circuit index and stimulus pattern, samples the muxed circuit
// output after a settle interval and emits one truth-table word per circuit.
module circuit_sweep_sequencer
  import circuit_sweep_sequencer_pkg::*;
#(
  parameter int NUM_CIRCUITS = DEF_NUM_CIRCUITS,
  parameter int PAT_W        = DEF_PAT_W,
  parameter int SETTLE_CYC   = DEF_SETTLE_CYC
) (
  input  logic                    CLOCK_50,
  input  logic                    RESET_N,
  input  logic                    start,
  input  logic                    abort,
  input  logic                    circ_out,
  output logic [SEL_W-1:0]        sel,
  output logic [PAT_W-1:0]        pattern,
  output logic                    busy,
  output logic                    res_valid,
  input  logic                    res_ready,
  output logic [SEL_W-1:0]        res_index,
  output logic [(1<<PAT_W)-1:0]   res_table,
  output logic                    done
);

  localparam int TBL_W = 1 << PAT_W;

  state_t             state_reg, state_next;
  logic [SEL_W-1:0]   sel_reg, sel_next;
  logic [PAT_W-1:0]   pattern_reg, pattern_next;
  logic [TBL_W-1:0]   table_reg, table_next;
  logic [SEL_W-1:0]   res_index_reg, res_index_next;
  logic               busy_reg, busy_next;
  logic               res_valid_reg, res_valid_next;
  logic               done_reg, done_next;
  logic               settle_expire;

  // The timer only runs in SETTLE and sits at zero otherwise, so every
  // entry into SETTLE starts a fresh interval.
  circuit_sweep_sequencer_settle_timer #(
    .SETTLE_CYC (SETTLE_CYC)
  ) u_settle_timer (
    .clk    (CLOCK_50),
    .rst_n  (RESET_N),
    .load   (state_reg != ST_SETTLE),
    .en     (state_reg == ST_SETTLE),
    .expire (settle_expire)
  );

  // Next-state and next-output logic; abort overrides everything outside IDLE.
  always_comb begin
    state_next     = state_reg;
    sel_next       = sel_reg;
    pattern_next   = pattern_reg;
    table_next     = table_reg;
    res_index_next = res_index_reg;

    case (state_reg)
      ST_IDLE: begin
        sel_next     = '0;
        pattern_next = '0;
        if (start && !abort) begin
          state_next = ST_SETTLE;
          table_next = '0;
        end
      end
      ST_SETTLE: begin
        if (settle_expire) begin
          state_next = ST_SAMPLE;
        end
      end
      ST_SAMPLE: begin
        table_next[pattern_reg] = circ_out;
        if (pattern_reg == {PAT_W{1'b1}}) begin
          state_next     = ST_EMIT;
          res_index_next = sel_reg;
        end else begin
          pattern_next = pattern_reg + PAT_W'(1);
          state_next   = ST_SETTLE;
        end
      end
      ST_EMIT: begin
        // sel, pattern and the table stay frozen until the consumer accepts.
        if (res_ready) begin
          if (sel_reg == SEL_W'(NUM_CIRCUITS - 1)) begin
            state_next = ST_FINISH;
          end else begin
            sel_next     = sel_reg + SEL_W'(1);
            pattern_next = '0;
            table_next   = '0;
            state_next   = ST_SETTLE;
          end
        end
      end
      ST_FINISH: begin
        sel_next     = '0;
        pattern_next = '0;
        state_next   = ST_IDLE;
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase

    if (abort && (state_reg != ST_IDLE)) begin
      state_next     = ST_IDLE;
      sel_next       = '0;
      pattern_next   = '0;
      table_next     = '0;
      res_index_next = '0;
    end

    busy_next      = (state_next != ST_IDLE);
    res_valid_next = (state_next == ST_EMIT);
    done_next      = (state_next == ST_FINISH);
  end

  // State and registered outputs.
  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      state_reg     <= ST_IDLE;
      sel_reg       <= '0;
      pattern_reg   <= '0;
      table_reg     <= '0;
      res_index_reg <= '0;
      busy_reg      <= 1'b0;
      res_valid_reg <= 1'b0;
      done_reg      <= 1'b0;
    end else begin
      state_reg     <= state_next;
      sel_reg       <= sel_next;
      pattern_reg   <= pattern_next;
      table_reg     <= table_next;
      res_index_reg <= res_index_next;
      busy_reg      <= busy_next;
      res_valid_reg <= res_valid_next;
      done_reg      <= done_next;
    end
  end

  assign sel       = sel_reg;
  assign pattern   = pattern_reg;
  assign busy      = busy_reg;
  assign res_valid = res_valid_reg;
  assign res_index = res_index_reg;
  assign res_table = table_reg;
  assign done      = done_reg;

endmodule

// File: tb/tb_circuit_sweep_sequencer.sv
// Directed bench for the circuit sweep sequencer: full sweeps against a model
// circuit bank, back-pressure, abort, asynchronous reset and a minimal config.
module tb_circuit_sweep_sequencer;

  logic clk = 1'b0;
  logic RESET_N;
  always #5 clk = ~clk;

  // Default-configuration instance.
  logic        start_a, abort_a, circ_out_a, res_ready_a;
  logic [4:0]  sel_a, pattern_a, res_index_a;
  logic        busy_a, res_valid_a, done_a;
  logic [31:0] res_table_a;

  // Minimal-configuration instance (one circuit, one settle cycle).
  logic        start_b, abort_b, circ_out_b, res_ready_b;
  logic [4:0]  sel_b, pattern_b, res_index_b;
  logic        busy_b, res_valid_b, done_b;
  logic [31:0] res_table_b;

  // Model circuit bank: circuit i outputs stimulus bit (i mod 5).
  assign circ_out_a = pattern_a[sel_a % 5'd5];
  assign circ_out_b = &pattern_b;

  circuit_sweep_sequencer #(.NUM_CIRCUITS(29), .PAT_W(5), .SETTLE_CYC(8)) dut_a (
    .CLOCK_50(clk), .RESET_N(RESET_N), .start(start_a), .abort(abort_a),
    .circ_out(circ_out_a), .sel(sel_a), .pattern(pattern_a), .busy(busy_a),
    .res_valid(res_valid_a), .res_ready(res_ready_a), .res_index(res_index_a),
    .res_table(res_table_a), .done(done_a)
  );

  circuit_sweep_sequencer #(.NUM_CIRCUITS(1), .PAT_W(5), .SETTLE_CYC(1)) dut_b (
    .CLOCK_50(clk), .RESET_N(RESET_N), .start(start_b), .abort(abort_b),
    .circ_out(circ_out_b), .sel(sel_b), .pattern(pattern_b), .busy(busy_b),
    .res_valid(res_valid_b), .res_ready(res_ready_b), .res_index(res_index_b),
    .res_table(res_table_b), .done(done_b)
  );

  typedef struct {
    logic [4:0]  idx;
    logic [31:0] tbl;
  } vec_t;

  vec_t        vecs[29];
  logic [31:0] bit_tables[5];
  int          checks = 0;
  int          errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // One full sweep on dut_a. Optionally holds res_ready low for hold_len
  // cycles at circuit hold_idx and pulses start at cycle glitch_at.
  task automatic run_sweep(input int hold_idx, input int hold_len, input int glitch_at);
    int t = 0;
    int c = 0;
    int exp_valid = 289;
    int exp_done = -1;
    int vstart = -1;
    int unstable = 0;
    bit fin = 1'b0;
    logic [4:0]  h_idx, h_sel, h_pat;
    logic [31:0] h_tbl;
    h_idx = '0; h_sel = '0; h_pat = '0; h_tbl = '0;
    @(negedge clk);
    start_a = 1'b1;
    res_ready_a = 1'b1;
    while (!fin) begin
      @(negedge clk);
      t++;
      start_a = (t == glitch_at);
      if (t > 20000) begin
        chk("sweep_timeout", 64'(t), 64'd0);
        fin = 1'b1;
      end else if (done_a) begin
        chk("done_cycle", 64'(t), 64'(exp_done));
        chk("result_count", 64'(c), 64'd29);
        fin = 1'b1;
      end else if (res_valid_a) begin
        if (c >= 29) begin
          chk("extra_result", 64'(c), 64'd28);
          fin = 1'b1;
        end else begin
          if (vstart < 0) begin
            vstart = t;
            chk("valid_cycle", 64'(t), 64'(exp_valid));
            chk("res_index", 64'(res_index_a), 64'(vecs[c].idx));
            chk("res_table", 64'(res_table_a), 64'(vecs[c].tbl));
            chk("sel_in_emit", 64'(sel_a), 64'(vecs[c].idx));
            h_idx = res_index_a; h_tbl = res_table_a; h_sel = sel_a; h_pat = pattern_a;
            unstable = 0;
          end else if (res_index_a !== h_idx || res_table_a !== h_tbl ||
                       sel_a !== h_sel || pattern_a !== h_pat) begin
            unstable++;
          end
          res_ready_a = !(c == hold_idx && t < vstart + hold_len);
          if (res_ready_a) begin
            $display("result idx=%0d table=%h valid_cycle=%0d accept_cycle=%0d",
                     res_index_a, res_table_a, vstart, t);
            if (c == hold_idx) begin
              chk("hold_stable", 64'(unstable), 64'd0);
              chk("hold_length", 64'(t - vstart), 64'(hold_len));
            end
            c++;
            vstart = -1;
            exp_valid = t + 289;
            if (c == 29) exp_done = t + 1;
          end
        end
      end else begin
        res_ready_a = 1'b1;
      end
    end
    start_a = 1'b0;
    res_ready_a = 1'b1;
    @(negedge clk);
    chk("idle_busy", 64'(busy_a), 64'd0);
    chk("idle_sel", 64'(sel_a), 64'd0);
    chk("idle_pattern", 64'(pattern_a), 64'd0);
    chk("done_one_cycle", 64'(done_a), 64'd0);
  endtask

  initial begin
    int t;
    int done_seen;

    bit_tables[0] = 32'hAAAAAAAA;
    bit_tables[1] = 32'hCCCCCCCC;
    bit_tables[2] = 32'hF0F0F0F0;
    bit_tables[3] = 32'hFF00FF00;
    bit_tables[4] = 32'hFFFF0000;
    for (int i = 0; i < 29; i++) begin
      vecs[i].idx = 5'(i);
      vecs[i].tbl = bit_tables[i % 5];
    end

    RESET_N = 1'b0;
    start_a = 1'b0; abort_a = 1'b0; res_ready_a = 1'b1;
    start_b = 1'b0; abort_b = 1'b0; res_ready_b = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_sel", 64'(sel_a), 64'd0);
    chk("rst_pattern", 64'(pattern_a), 64'd0);
    chk("rst_busy", 64'(busy_a), 64'd0);
    chk("rst_valid", 64'(res_valid_a), 64'd0);
    chk("rst_index", 64'(res_index_a), 64'd0);
    chk("rst_table", 64'(res_table_a), 64'd0);
    chk("rst_done", 64'(done_a), 64'd0);
    RESET_N = 1'b1;
    @(negedge clk);

    // Full sweep with ready held high and a stray start at cycle 500.
    run_sweep(-1, 0, 500);

    // Abort inside circuit 3.
    @(negedge clk);
    start_a = 1'b1;
    for (int i = 1; i <= 1000; i++) begin
      @(negedge clk);
      start_a = 1'b0;
    end
    chk("pre_abort_sel", 64'(sel_a), 64'd3);
    abort_a = 1'b1;
    @(negedge clk);
    abort_a = 1'b0;
    chk("abort_busy", 64'(busy_a), 64'd0);
    chk("abort_valid", 64'(res_valid_a), 64'd0);
    chk("abort_sel", 64'(sel_a), 64'd0);
    chk("abort_pattern", 64'(pattern_a), 64'd0);
    done_seen = 0;
    for (int i = 0; i < 20; i++) begin
      if (done_a) done_seen++;
      @(negedge clk);
    end
    chk("abort_no_done", 64'(done_seen), 64'd0);

    // start and abort together in IDLE: stays idle.
    start_a = 1'b1;
    abort_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    abort_a = 1'b0;
    chk("start_abort_busy", 64'(busy_a), 64'd0);
    @(negedge clk);
    chk("start_abort_pattern", 64'(pattern_a), 64'd0);

    // Re-sweep from index 0 with back-pressure at index 3.
    run_sweep(3, 50, -1);

    // Reset asserted while a result is waiting.
    @(negedge clk);
    start_a = 1'b1;
    res_ready_a = 1'b0;
    t = 0;
    while (!res_valid_a && t < 400) begin
      @(negedge clk);
      start_a = 1'b0;
      t++;
    end
    chk("emit_reach_cycle", 64'(t), 64'd289);
    #2 RESET_N = 1'b0;
    #1;
    chk("async_rst_valid", 64'(res_valid_a), 64'd0);
    chk("async_rst_busy", 64'(busy_a), 64'd0);
    chk("async_rst_table", 64'(res_table_a), 64'd0);
    chk("async_rst_sel_pat", 64'({sel_a, pattern_a}), 64'd0);
    @(negedge clk);
    RESET_N = 1'b1;
    res_ready_a = 1'b1;
    repeat (3) @(negedge clk);
    chk("post_rst_idle", 64'({busy_a, res_valid_a, done_a}), 64'd0);

    // Minimal configuration: one circuit, one settle cycle, AND circuit.
    start_b = 1'b1;
    res_ready_b = 1'b1;
    t = 0;
    do begin
      @(negedge clk);
      start_b = 1'b0;
      t++;
    end while (!res_valid_b && t < 200);
    chk("small_valid_cycle", 64'(t), 64'd65);
    chk("small_index", 64'(res_index_b), 64'd0);
    chk("small_table", 64'(res_table_b), 64'h80000000);
    $display("result idx=%0d table=%h valid_cycle=%0d (minimal config)", res_index_b, res_table_b, t);
    @(negedge clk);
    chk("small_done", 64'(done_b), 64'd1);
    @(negedge clk);
    chk("small_done_pulse", 64'(done_b), 64'd0);
    chk("small_idle", 64'(busy_b), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/circuit_sweep_sequencer.md
# circuit_sweep_sequencer

Autonomous sweep controller for the evolved-circuit test harness. In place of the operator setting the circuit-select and stimulus switches by hand, it walks every circuit index and every input pattern, waits a settle interval, samples the selected circuit's output bit, and emits one truth-table word per circuit over a valid/ready handshake. It sits between the board-level circuit multiplexer (drives select and stimulus, reads the muxed output) and a result consumer (display, UART or memory writer).

## Interface
- NUM_CIRCUITS, 29: number of circuit indices swept, 0..NUM_CIRCUITS-1; range 1..32
- PAT_W, 5: stimulus width; 2^PAT_W patterns per circuit
- SETTLE_CYC, 8: wait cycles between driving a pattern and sampling; must be ≥1
- CLOCK_50  in  1  system clock, all logic on rising edge
- RESET_N  in  1  asynchronous, active-low reset
- start  in  1  one-cycle request to begin a full sweep
- abort  in  1  terminate the sweep immediately
- circ_out  in  1  muxed output bit of the currently selected circuit
- sel  out  5  circuit index driven to the harness multiplexer
- pattern  out  PAT_W  stimulus driven to all circuits
- busy  out  1  high from the cycle after an accepted start until return to IDLE
- res_valid  out  1  result word available
- res_ready  in  1  consumer accepts the result
- res_index  out  5  circuit index of the current result
- res_table  out  2^PAT_W  bit k = sampled output for pattern k
- done  out  1  one-cycle pulse after the last result is accepted

## Operation
- States: IDLE, SETTLE, SAMPLE, EMIT, FINISH.
- IDLE: busy=0. start=1 -> SETTLE with sel=0, pattern=0, settle counter=0, res_table cleared.
- SETTLE: counter increments each cycle; when counter reaches SETTLE_CYC-1 -> SAMPLE.
- SAMPLE (one cycle): res_table[pattern] <= circ_out. If pattern=2^PAT_W-1 -> EMIT; else pattern+1, counter=0 -> SETTLE.
- EMIT: res_valid=1, res_index=sel. Hold until res_valid&res_ready. On handshake: if sel=NUM_CIRCUITS-1 -> FINISH; else sel+1, pattern=0, counter=0, res_table cleared -> SETTLE.
- FINISH (one cycle): done=1 -> IDLE. sel/pattern return to 0 in IDLE.
- start while busy: ignored. start and abort together in IDLE: abort wins, stays IDLE.
- abort=1 in any non-IDLE state: next cycle IDLE, res_valid=0, done not pulsed, sel/pattern=0, partial table discarded.
- res_index and res_table stable while res_valid=1 and not accepted; sel and pattern also frozen during EMIT.
- pattern increment never wraps mid-circuit; wrap to 0 only through EMIT handshake.

## Timing
- Reset values: sel=0, pattern=0, busy=0, res_valid=0, res_index=0, res_table=0, done=0, state IDLE. Reset mid-sweep behaves as abort, asynchronously.
- All outputs registered.
- Each pattern occupies SETTLE_CYC+1 cycles; circ_out sampled on the edge ending the SAMPLE cycle, i.e. ≥SETTLE_CYC+1 cycles after pattern changes.
- Per circuit, ready held high: 2^PAT_W·(SETTLE_CYC+1) + 1 cycles. Defaults: 32·9+1 = 289 cycles; full sweep 29·289 + 1 (FINISH) = 8382 cycles from start to done.
- First res_valid rises 1 + 2^PAT_W·(SETTLE_CYC+1) cycles after the start edge (289 at defaults).

## Structure
- Shared package: state enum, default constants NUM_CIRCUITS=29, SEL_W=5, PAT_W=5.
- One sub-module: settle_timer (load/count/expire, width from SETTLE_CYC); everything else in the top FSM.

## Test plan
- Model circuit circ_out=pattern[0], defaults, res_ready=1: index 0 result res_table=32'hAAAAAAAA, 29 results indices 0..28, done at cycle 8382.
- res_ready low 50 cycles at index 3: res_valid held, res_index=3 and table constant, sel stays 3, no pattern change; resumes on accept.
- abort at cycle 1000 (inside circuit 3): next cycle busy=0, res_valid=0, sel=0, pattern=0, no done; new start re-sweeps from index 0.
- RESET_N low mid-EMIT: outputs zero immediately, no result lost-ack; after release IDLE until start.
- start pulsed at cycle 500 while busy: no effect on sel/pattern sequence or cycle counts.
- SETTLE_CYC=1, NUM_CIRCUITS=1, circ_out=&pattern: single result 32'h80000000 after 65 cycles, done one cycle after accept.
